// File: rtl/button_events.sv
// button_events: turns debounced per-button edge pulses into PRESS / REPEAT /
// RELEASE events, tracking one button at a time, queued in a small FIFO.
// Ports: clk, rstn (sync, active low), btn_level/btn_rise/btn_fall [WIDTH],
//        event_valid/event_data/event_ready (FWFT handshake), overflow (sticky).
// Option: BUTTON_EVENTS_AUTOREPEAT_EN builds the hold/repeat counter and REPEAT.
module button_events #(
    parameter int WIDTH         = 4,
    parameter int HOLD_LIMIT    = 25_000_000,
    parameter int REPEAT_PERIOD = 5_000_000,
    parameter int DEPTH         = 4,
    localparam int IDXW         = (WIDTH > 1) ? $clog2(WIDTH) : 1,
    localparam int DW           = 2 + IDXW
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [WIDTH-1:0] btn_level,
    input  logic [WIDTH-1:0] btn_rise,
    input  logic [WIDTH-1:0] btn_fall,
    output logic             event_valid,
    output logic [DW-1:0]    event_data,
    input  logic             event_ready,
    output logic             overflow
);

    localparam logic [1:0] K_PRESS   = 2'b00;
    localparam logic [1:0] K_REPEAT  = 2'b01;
    localparam logic [1:0] K_RELEASE = 2'b10;
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    typedef enum logic [1:0] {S_IDLE, S_HOLD, S_REPEAT} state_t;

    state_t          state_q, state_d;
    logic [IDXW-1:0] active_q, active_d;
    logic [IDXW-1:0] rise_idx;
    logic            rise_any;
    logic            gone;
    logic            push;
    logic [DW-1:0]   push_data;

`ifdef BUTTON_EVENTS_AUTOREPEAT_EN
    localparam int CMAX = (HOLD_LIMIT > REPEAT_PERIOD) ? HOLD_LIMIT : REPEAT_PERIOD;
    localparam int CNTW = $clog2(CMAX);
    localparam logic [CNTW-1:0] HOLD_LOAD = CNTW'(HOLD_LIMIT - 1);
    localparam logic [CNTW-1:0] REP_LOAD  = CNTW'(REPEAT_PERIOD - 1);
    logic [CNTW-1:0] cnt_q, cnt_d;
`else
    logic unused_cfg;
    assign unused_cfg = (HOLD_LIMIT + REPEAT_PERIOD) > 0;
`endif

    // Lowest-numbered rising button wins; scan downward so it is written last.
    always_comb begin
        rise_any = |btn_rise;
        rise_idx = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (btn_rise[i]) rise_idx = IDXW'(i);
        end
    end

    // A low level on the active button also ends the hold (missed fall pulse).
    assign gone = btn_fall[active_q] || !btn_level[active_q];

    always_comb begin
        state_d   = state_q;
        active_d  = active_q;
        push      = 1'b0;
        push_data = '0;
`ifdef BUTTON_EVENTS_AUTOREPEAT_EN
        cnt_d     = cnt_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (rise_any) begin
                    active_d  = rise_idx;
                    push      = 1'b1;
                    push_data = {K_PRESS, rise_idx};
                    state_d   = S_HOLD;
`ifdef BUTTON_EVENTS_AUTOREPEAT_EN
                    cnt_d     = HOLD_LOAD;
`endif
                end
            end
            S_HOLD, S_REPEAT: begin
                if (gone) begin
                    push      = 1'b1;
                    push_data = {K_RELEASE, active_q};
                    state_d   = S_IDLE;
                end
`ifdef BUTTON_EVENTS_AUTOREPEAT_EN
                else if (cnt_q == '0) begin
                    push      = 1'b1;
                    push_data = {K_REPEAT, active_q};
                    cnt_d     = REP_LOAD;
                    state_d   = S_REPEAT;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
`endif
            end
            default: state_d = S_IDLE;
        endcase
    end

    logic [DW-1:0] mem_q [DEPTH];
    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic          overflow_q, overflow_d;
    logic          empty, full, pop, wr;

    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[AW] != rptr_q[AW]) &&
                   (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign pop   = !empty && event_ready;
    // A simultaneous pop frees the slot, so a push into a full FIFO still fits.
    assign wr    = push && (!full || pop);

    always_comb begin
        wptr_d     = wptr_q + PW'(wr);
        rptr_d     = rptr_q + PW'(pop);
        overflow_d = overflow_q | (push & ~wr);
    end

    assign event_valid = !empty;
    assign event_data  = empty ? '0 : mem_q[rptr_q[AW-1:0]];
    assign overflow    = overflow_q;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q    <= S_IDLE;
            active_q   <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            overflow_q <= 1'b0;
`ifdef BUTTON_EVENTS_AUTOREPEAT_EN
            cnt_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            active_q   <= active_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            overflow_q <= overflow_d;
`ifdef BUTTON_EVENTS_AUTOREPEAT_EN
            cnt_q      <= cnt_d;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rstn && wr) mem_q[wptr_q[AW-1:0]] <= push_data;
    end

endmodule

// File: tb/tb_button_events.sv
// tb_button_events: directed + random stimulus, event-level reference model,
// scoreboard queue checked by a negedge monitor.
module tb_button_events;

    localparam int WIDTH = 4;
    localparam int HOLD  = 8;
    localparam int REP   = 4;
    localparam int DEPTH = 4;
    localparam int DW    = 4;
`ifdef BUTTON_EVENTS_AUTOREPEAT_EN
    localparam bit AUTOREP = 1'b1;
`else
    localparam bit AUTOREP = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rstn;
    logic [WIDTH-1:0] btn_level, btn_rise, btn_fall;
    logic             event_valid, event_ready, overflow;
    logic [DW-1:0]    event_data;

    always #5 clk = ~clk;

    button_events #(
        .WIDTH(WIDTH), .HOLD_LIMIT(HOLD), .REPEAT_PERIOD(REP), .DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rstn(rstn),
        .btn_level(btn_level), .btn_rise(btn_rise), .btn_fall(btn_fall),
        .event_valid(event_valid), .event_data(event_data),
        .event_ready(event_ready), .overflow(overflow)
    );

    int checks = 0;
    int passes = 0;

    logic [DW-1:0] exp_q[$];
    bit   m_held = 0;
    int   m_idx  = 0;
    int   m_t    = 0;
    int   m_cnt  = 0;
    bit   m_ovf  = 0;
    bit   m_rst  = 0;
    logic [WIDTH-1:0] lvl = '0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [DW-1:0] ev(input int kind, input int idx);
        return DW'((kind << 2) | idx);
    endfunction

    // Reference model: which button is held and for how many edges; repeats
    // fall where elapsed time hits HOLD + k*REP. FIFO is modelled by occupancy.
    always @(posedge clk) begin : model
        bit            has;
        bit            popm;
        logic [DW-1:0] e;
        has = 0;
        e   = '0;
        if (!rstn) begin
            m_held = 0;
            m_cnt  = 0;
            m_ovf  = 0;
            m_rst  = 1;
            exp_q.delete();
        end else begin
            m_rst = 0;
            popm  = (m_cnt > 0) && event_ready;
            if (!m_held) begin
                if (btn_rise != '0) begin
                    for (int i = WIDTH - 1; i >= 0; i--)
                        if (btn_rise[i]) m_idx = i;
                    m_held = 1;
                    m_t    = 0;
                    has    = 1;
                    e      = ev(0, m_idx);
                end
            end else begin
                m_t++;
                if (btn_fall[m_idx] || !btn_level[m_idx]) begin
                    has    = 1;
                    e      = ev(2, m_idx);
                    m_held = 0;
                end else if (AUTOREP && m_t >= HOLD && (m_t - HOLD) % REP == 0) begin
                    has = 1;
                    e   = ev(1, m_idx);
                end
            end
            if (popm) m_cnt--;
            if (has) begin
                if (m_cnt < DEPTH) begin
                    m_cnt++;
                    exp_q.push_back(e);
                end else begin
                    m_ovf = 1;
                end
            end
        end
    end

    always @(negedge clk) begin : monitor
        check("event_valid", {31'b0, event_valid}, {31'b0, (m_cnt > 0)});
        check("overflow", {31'b0, overflow}, {31'b0, m_ovf});
        if (m_rst) check("reset_data", {28'b0, event_data}, 32'd0);
        if (event_valid && event_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                $display("FAIL extra_event: got %0h required none at %0t",
                         event_data, $time);
            end else begin
                check("event_data", {28'b0, event_data}, {28'b0, exp_q.pop_front()});
            end
        end
    end

    task automatic step(input logic [WIDTH-1:0] nl, input bit drop_f = 0,
                        input bit drop_r = 0);
        btn_rise  = drop_r ? '0 : (nl & ~lvl);
        btn_fall  = drop_f ? '0 : (lvl & ~nl);
        lvl       = nl;
        btn_level = nl;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step('0);
    endtask

    initial begin
        logic [WIDTH-1:0] nl;
        rstn        = 1'b0;
        event_ready = 1'b1;
        btn_level   = '0;
        btn_rise    = '0;
        btn_fall    = '0;
        repeat (3) @(posedge clk);
        #1;
        rstn = 1'b1;
        idle(3);

        // long hold of button 2: press, three repeats, release
        step(4'b0100);
        repeat (17) step(4'b0100);
        step(4'b0000);
        idle(4);

        // short tap of button 1
        step(4'b0010);
        repeat (4) step(4'b0010);
        step(4'b0000);
        idle(4);

        // simultaneous rises on 1 and 3; only 1 is tracked
        step(4'b1010);
        step(4'b1010);
        step(4'b0010);
        repeat (3) step(4'b0010);
        step(4'b0000);
        idle(4);

        // backpressure: FIFO fills, later events dropped, then drains
        event_ready = 1'b0;
        step(4'b0001);
        repeat (30) step(4'b0001);
        step(4'b0000);
        event_ready = 1'b1;
        idle(8);

        // fall coincides with the first repeat slot
        step(4'b0001);
        repeat (7) step(4'b0001);
        step(4'b0000);
        idle(4);

        // reset while held: no new PRESS without a fresh rise
        step(4'b0100);
        repeat (12) step(4'b0100);
        rstn = 1'b0;
        step(4'b0100);
        rstn = 1'b1;
        repeat (5) step(4'b0100);
        step(4'b0000);
        idle(4);

        // lost fall pulse: level drop alone releases
        step(4'b1000);
        repeat (3) step(4'b1000);
        step(4'b0000, 1'b1);
        idle(4);

        for (int n = 0; n < 3000; n++) begin
            nl = lvl;
            if ($urandom_range(0, 9) == 0)
                nl = nl ^ (4'b0001 << $urandom_range(0, 3));
            event_ready = ($urandom_range(0, 3) != 0);
            if (n % 700 >= 650) event_ready = 1'b0;
            rstn = !(n % 1000 == 999);
            step(nl, $urandom_range(0, 4) == 0, $urandom_range(0, 7) == 0);
        end

        rstn        = 1'b1;
        event_ready = 1'b1;
        idle(12);
        check("drained", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
